// File: rtl/fpu_comparator.sv
// Signed a - b comparator stage: registered difference, true signed order, equality and overflow.
// Optional `FPU_CMP_ABS_EN` adds the abs_diff output (|a - b| as unsigned).
module fpu_comparator #(
  parameter int unsigned size = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic            out_valid,
  output logic [size-1:0] difference,
  output logic            sign,
  output logic            eq,
`ifdef FPU_CMP_ABS_EN
  output logic [size-1:0] abs_diff,
`endif
  output logic            ovf
);

  localparam int unsigned MSB  = size - 1;
  localparam int unsigned WIDE = size + 1;

  logic [size-1:0] diff_c;
  logic            ovf_c;
  logic            eq_c;
  logic            sign_c;

  // Two's complement subtract; carry out is dropped, so the result wraps.
  always_comb begin
    diff_c = a + ~b + size'(1);
    ovf_c  = (a[MSB] != b[MSB]) && (diff_c[MSB] != a[MSB]);
    eq_c   = (diff_c == '0);
    sign_c = eq_c ? 1'b0 : (diff_c[MSB] ^ ovf_c);
  end

`ifdef FPU_CMP_ABS_EN
  logic [size:0]   wide_c;
  logic [size-1:0] abs_c;

  // Sign-extended difference never overflows, so its magnitude fits in size bits.
  always_comb begin
    wide_c = {a[MSB], a} - {b[MSB], b};
    abs_c  = size'(wide_c[size] ? (~wide_c + WIDE'(1)) : wide_c);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      difference <= '0;
      sign       <= 1'b0;
      eq         <= 1'b0;
      ovf        <= 1'b0;
`ifdef FPU_CMP_ABS_EN
      abs_diff   <= '0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        difference <= diff_c;
        sign       <= sign_c;
        eq         <= eq_c;
        ovf        <= ovf_c;
`ifdef FPU_CMP_ABS_EN
        abs_diff   <= abs_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fpu_comparator.sv
// Directed self-checking bench for fpu_comparator (size=32), with abs_diff checks under FPU_CMP_ABS_EN.
module tb_fpu_comparator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] difference;
  logic        sign;
  logic        eq;
  logic        ovf;
`ifdef FPU_CMP_ABS_EN
  logic [31:0] abs_diff;
`endif

  int checks = 0;
  int passed = 0;

  fpu_comparator #(.size(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .difference (difference),
    .sign       (sign),
    .eq         (eq),
`ifdef FPU_CMP_ABS_EN
    .abs_diff   (abs_diff),
`endif
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Drive on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic step(input logic r, input logic v, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    rst = r; in_valid = v; a = x; b = y;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic v, input logic [31:0] d,
                            input logic s, input logic e, input logic o);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".diff"},  difference, d);
    check({tag, ".sign"},  32'(sign), 32'(s));
    check({tag, ".eq"},    32'(eq), 32'(e));
    check({tag, ".ovf"},   32'(ovf), 32'(o));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    step(1'b1, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 32'd77, 32'd3);
    expect_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    step(1'b0, 1'b1, 32'd10, 32'd5);
    expect_all("10-5", 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);

    step(1'b0, 1'b1, 32'd5, 32'd10);
    expect_all("5-10", 1'b1, 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b0);
`ifdef FPU_CMP_ABS_EN
    check("5-10.abs", abs_diff, 32'd5);
`endif

    step(1'b0, 1'b1, 32'd10, 32'd10);
    expect_all("10-10", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);

    step(1'b0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFF6);
    expect_all("neg5-neg10", 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);

    step(1'b0, 1'b1, 32'h8000_0000, 32'd1);
    expect_all("min-1", 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);

    step(1'b0, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    expect_all("max-neg1", 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);

    step(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
    expect_all("min-min", 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);

    step(1'b0, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF);
    expect_all("min-max", 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
`ifdef FPU_CMP_ABS_EN
    check("min-max.abs", abs_diff, 32'hFFFF_FFFF);
`endif

    step(1'b0, 1'b1, 32'hFFFF_FFFB, 32'd10);
    expect_all("neg5-10", 1'b1, 32'hFFFF_FFF1, 1'b1, 1'b0, 1'b0);
`ifdef FPU_CMP_ABS_EN
    check("neg5-10.abs", abs_diff, 32'd15);
`endif

    // Idle cycle: valid drops, results hold even though operands change.
    step(1'b0, 1'b0, 32'd1, 32'd1);
    expect_all("idle", 1'b0, 32'hFFFF_FFF1, 1'b1, 1'b0, 1'b0);
`ifdef FPU_CMP_ABS_EN
    check("idle.abs", abs_diff, 32'd15);
`endif

    // Reset beats in_valid and discards the pair.
    step(1'b1, 1'b1, 32'd3, 32'd1);
    expect_all("rst-mid", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef FPU_CMP_ABS_EN
    check("rst-mid.abs", abs_diff, 32'd0);
`endif

    step(1'b0, 1'b0, 32'd9, 32'd2);
    expect_all("post-rst-idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    step(1'b0, 1'b1, 32'd7, 32'd2);
    expect_all("post-rst", 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);

    step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0);
    expect_all("neg1-0", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
